miinst_issue_sequencer: RTL and testbench
=========================================

# miinst_issue_sequencer

Sequences the micro-instruction bundles produced by the fetch phases (opcode, ModRM, SIB, displacement, immediate). It holds one decoded bundle of `MQ_N` micro-instruction slots and issues the non-empty slots to the execute stage, one per cycle, in ascending slot order, over a valid/ready handshake. It applies back-pressure to fetch and supports a pipeline flush. It sits between the fetch phase mux and the execute/dispatch stage.

## Interface
- `N`, default `` `MQ_N ``: number of micro-instruction slots per bundle. Slot index order is the required execution order (e.g. `MQ_SCALE` before `MQ_LOAD`).
- `clk`  in  1: clock; all state updates on the rising edge.
- `rstn`  in  1: reset, asynchronous, active-low.
- `flush`  in  1: discard the held bundle (branch redirect or exception).
- `fetch_valid`  in  1: fetch presents a complete bundle.
- `fetch_miinst`  in  miinst_t[N]: bundle slots; a slot whose `op == MIOP_NOP` is empty.
- `fetch_pc`  in  addr_t: pc of the x86 instruction the bundle came from.
- `fetch_ready`  out  1: sequencer accepts the bundle this cycle.
- `issue_valid`  out  1: `issue_inst` is valid.
- `issue_inst`  out  miinst_t: micro-instruction being issued.
- `issue_pc`  out  addr_t: pc of the owning bundle.
- `issue_last`  out  1: this is the last non-empty slot of the bundle.
- `issue_ready`  in  1: execute accepts `issue_inst`.
- `busy`  out  1: a bundle is held (state ISSUE).

## Operation
- Registers:
  - `buf[N]` (miinst_t), `pc_q`.
  - `pend[N-1:0]`: pending mask, one bit per non-empty slot not yet issued.
  - `state`: IDLE or ISSUE.
- Current slot `cur` is the lowest set bit of `pend` (priority encoder).
- Outputs:
  - `issue_inst = buf[cur]`, `issue_pc = pc_q`.
  - `issue_valid = (state==ISSUE)`.
  - `issue_last = (pend` has exactly one bit set`)`.
  - `busy = (state==ISSUE)`.
- `fetch_ready = !flush && (state==IDLE || (issue_valid && issue_ready && issue_last))`.
- Accept (`fetch_valid && fetch_ready`):
  - Load `buf` and `pc_q`.
  - `pend[i] = (fetch_miinst[i].op != MIOP_NOP)`.
  - If the new `pend` is non-zero, go to ISSUE; otherwise go to (or stay in) IDLE. An all-NOP bundle is consumed with no issue.
- Issue handshake (`issue_valid && issue_ready`): clear `pend[cur]`. If this was the last slot and no accept happens in the same cycle, go to IDLE.
- Last-slot accept and a new-bundle accept in the same cycle: the new bundle is loaded. The cleared old bit is overwritten, giving back-to-back issue with no bubble.
- `flush` has top priority:
  - Next state IDLE, `pend` cleared.
  - Any concurrent `fetch_valid` is dropped (`fetch_ready` is 0).
  - `issue_valid` may still be 1 in the flush cycle; execute ignores issue under flush, so the sequencer records no handshake in that cycle.
- While `issue_valid && !issue_ready`, `issue_inst`, `issue_pc` and `issue_last` hold stable.

## Timing
- Reset (`rstn` low, asynchronous):
  - state IDLE, `pend` 0, `buf` all-zero, `pc_q` 0.
  - Hence `issue_valid` 0, `busy` 0, `issue_inst` 0, `issue_last` 0.
  - `fetch_ready` is 1 once `flush` is low.
- Reset asserted mid-bundle drops all pending slots immediately; nothing is issued afterwards.
- Latency: a bundle accepted at edge k has its first slot valid in cycle k+1.
- A bundle with M non-empty slots and `issue_ready` held high occupies M cycles.
- Sustained throughput is 1 micro-instruction per cycle, including across bundle boundaries.
- No combinational path from `fetch_valid` to `issue_valid`.
- `fetch_ready` depends combinationally on `issue_ready`.
- No combinational path from `fetch_*` to any `issue_*` output.

## Test plan
- **Reset then single SIB bundle.**
  - Stimulus: release reset; present slots {SCALE: SLLI, LOAD: LD, others NOP}, pc=0x1000; hold `issue_ready`=1.
  - Required: SLLI with `issue_last`=0, then LD with `issue_last`=1, on consecutive cycles, both `issue_pc`=0x1000; then `busy`=0.
- **Back-pressure.**
  - Stimulus: same bundle; `issue_ready`=0 for 3 cycles, then 1.
  - Required: SLLI held stable for 4 cycles; `fetch_ready`=0 throughout; LD follows.
- **Back-to-back bundles.**
  - Stimulus: bundle A (2 slots, pc 0x10) followed immediately by bundle B (1 slot, pc 0x14); `issue_ready`=1.
  - Required: B is accepted in A's last-issue cycle; 3 consecutive `issue_valid` cycles with no bubble.
- **All-NOP bundle.**
  - Stimulus: bundle with every slot NOP.
  - Required: accepted; `issue_valid` stays 0; `fetch_ready` stays 1 in the next cycle.
- **Flush mid-bundle.**
  - Stimulus: 3-slot bundle; assert `flush` after the first issue, with `fetch_valid` high in the same cycle.
  - Required: next cycle `issue_valid`=0 and `busy`=0; the concurrent bundle is not accepted.
- **Async reset mid-bundle.**
  - Stimulus: drop `rstn` between clock edges while slot 1 is pending.
  - Required: `issue_valid` goes to 0 immediately without waiting for a clock edge; after release, no stale slot is issued.

Source files
------------

// File: rtl/miinst_issue_sequencer.sv
// Micro-instruction issue sequencer: holds one decoded bundle and issues its non-empty
// slots to execute, one per cycle in ascending slot order, over a valid/ready handshake.
`ifndef MQ_N
`define MQ_N 8
`endif

package miinst_pkg;
    localparam int unsigned MQ_N = `MQ_N;

    // Slot indices; index order is execution order.
    localparam int unsigned MQ_SEG   = 0;
    localparam int unsigned MQ_SCALE = 1;
    localparam int unsigned MQ_DISP  = 2;
    localparam int unsigned MQ_LOAD  = 3;
    localparam int unsigned MQ_ALU   = 4;
    localparam int unsigned MQ_IMM   = 5;
    localparam int unsigned MQ_STORE = 6;
    localparam int unsigned MQ_WB    = 7;

    typedef logic [31:0] addr_t;

    typedef enum logic [3:0] {
        MIOP_NOP  = 4'd0,
        MIOP_SLLI = 4'd1,
        MIOP_LD   = 4'd2,
        MIOP_ADD  = 4'd3,
        MIOP_ST   = 4'd4,
        MIOP_MOV  = 4'd5
    } miop_e;

    typedef struct packed {
        miop_e       op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } miinst_t;
endpackage

module miinst_issue_sequencer
    import miinst_pkg::*;
#(
    parameter int unsigned N = MQ_N
) (
    input  logic    clk,
    input  logic    rstn,
    input  logic    flush,
    input  logic    fetch_valid,
    input  miinst_t fetch_miinst [N],
    input  addr_t   fetch_pc,
    output logic    fetch_ready,
    output logic    issue_valid,
    output miinst_t issue_inst,
    output addr_t   issue_pc,
    output logic    issue_last,
    input  logic    issue_ready,
    output logic    busy
);

    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [0:0] {
        StIdle,
        StIssue
    } state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    pend_q, pend_d, pend_new;
    miinst_t         slot_q [N];
    addr_t           pc_q;
    logic [IdxW-1:0] cur;
    logic            accept;
    logic            fire;

    // Lowest pending slot is issued first.
    always_comb begin
        cur = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pend_q[i]) cur = IdxW'(i);
        end
    end

    always_comb begin
        pend_new = '0;
        for (int i = 0; i < N; i++) begin
            pend_new[i] = (fetch_miinst[i].op != MIOP_NOP);
        end
    end

    assign issue_valid = (state_q == StIssue);
    assign busy        = (state_q == StIssue);
    assign issue_inst  = slot_q[cur];
    assign issue_pc    = pc_q;
    assign issue_last  = (pend_q != '0) && ((pend_q & (pend_q - N'(1))) == '0);

    assign fetch_ready = !flush && ((state_q == StIdle) ||
                                    (issue_valid && issue_ready && issue_last));
    assign accept      = fetch_valid && fetch_ready;
    // Execute ignores issue under flush, so no handshake is recorded then.
    assign fire        = issue_valid && issue_ready && !flush;

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        if (flush) begin
            state_d = StIdle;
            pend_d  = '0;
        end else if (accept) begin
            // Overwrites the just-cleared last bit of the old bundle: no bubble.
            pend_d  = pend_new;
            state_d = (pend_new != '0) ? StIssue : StIdle;
        end else if (fire) begin
            pend_d[cur] = 1'b0;
            if (issue_last) state_d = StIdle;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            pend_q  <= '0;
            pc_q    <= '0;
            for (int i = 0; i < N; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            if (accept) begin
                pc_q <= fetch_pc;
                for (int i = 0; i < N; i++) begin
                    slot_q[i] <= fetch_miinst[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_miinst_issue_sequencer.sv
// Bench for miinst_issue_sequencer: directed scenarios then random traffic, checked by a
// queue-based reference model of the remaining micro-instructions of the held bundle.
module tb_miinst_issue_sequencer;
    import miinst_pkg::*;

    localparam int unsigned N = MQ_N;

    logic    clk;
    logic    rstn;
    logic    flush;
    logic    fetch_valid;
    miinst_t fetch_miinst [N];
    addr_t   fetch_pc;
    logic    fetch_ready;
    logic    issue_valid;
    miinst_t issue_inst;
    addr_t   issue_pc;
    logic    issue_last;
    logic    issue_ready;
    logic    busy;

    miinst_issue_sequencer #(.N(N)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .flush        (flush),
        .fetch_valid  (fetch_valid),
        .fetch_miinst (fetch_miinst),
        .fetch_pc     (fetch_pc),
        .fetch_ready  (fetch_ready),
        .issue_valid  (issue_valid),
        .issue_inst   (issue_inst),
        .issue_pc     (issue_pc),
        .issue_last   (issue_last),
        .issue_ready  (issue_ready),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        miinst_t inst;
        addr_t   pc;
        bit      last;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   n_issued = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the held bundle is just the ordered list of its non-NOP slots.
    int sz;
    bit hs;
    bit acc;
    int last_i;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            exp_q.delete();
        end else begin
            sz  = exp_q.size();
            hs  = (sz != 0) && issue_ready && !flush;
            acc = !flush && fetch_valid && (sz == 0 || (sz == 1 && issue_ready));
            if (flush) begin
                exp_q.delete();
            end else begin
                if (hs) begin
                    void'(exp_q.pop_front());
                    n_issued++;
                end
                if (acc) begin
                    last_i = -1;
                    for (int i = 0; i < N; i++) if (fetch_miinst[i].op != MIOP_NOP) last_i = i;
                    for (int i = 0; i < N; i++) begin
                        if (fetch_miinst[i].op != MIOP_NOP)
                            exp_q.push_back('{inst: fetch_miinst[i], pc: fetch_pc,
                                              last: (i == last_i)});
                    end
                end
            end
        end
    end

    // Monitor: compares DUT outputs against the model mid-cycle.
    always @(negedge clk) begin
        check("issue_valid", 64'(issue_valid), 64'(exp_q.size() != 0));
        check("busy", 64'(busy), 64'(exp_q.size() != 0));
        check("fetch_ready", 64'(fetch_ready),
              64'(!flush && (exp_q.size() == 0 || (exp_q.size() == 1 && issue_ready))));
        if (exp_q.size() != 0 && issue_valid) begin
            check("issue_inst", 64'(issue_inst), 64'(exp_q[0].inst));
            check("issue_pc", 64'(issue_pc), 64'(exp_q[0].pc));
            check("issue_last", 64'(issue_last), 64'(exp_q[0].last));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_bundle();
        for (int i = 0; i < N; i++) fetch_miinst[i] = '0;
    endtask

    task automatic put_slot(input int idx, input miop_e op);
        miinst_t m;
        m.op  = op;
        m.rd  = 5'($urandom());
        m.rs1 = 5'($urandom());
        m.rs2 = 5'($urandom());
        m.imm = $urandom();
        fetch_miinst[idx] = m;
    endtask

    task automatic fill_bundle(input logic [N-1:0] mask, input addr_t pc);
        clear_bundle();
        for (int i = 0; i < N; i++) begin
            if (mask[i]) put_slot(i, miop_e'($urandom_range(1, 5)));
        end
        fetch_pc = pc;
    endtask

    // Called at posedge+1; holds fetch_valid until the bundle is taken.
    task automatic send(input int budget);
        int k;
        k = 0;
        fetch_valid = 1'b1;
        @(negedge clk);
        while (!fetch_ready && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (!fetch_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: got no fetch_ready expected fetch_ready within %0d", budget);
        end
        @(posedge clk);
        #1;
        fetch_valid = 1'b0;
    endtask

    logic [N-1:0] m;

    initial begin
        rstn        = 1'b0;
        flush       = 1'b0;
        fetch_valid = 1'b0;
        issue_ready = 1'b0;
        fetch_pc    = '0;
        clear_bundle();
        #12;
        check("rst_issue_valid", 64'(issue_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_issue_inst", 64'(issue_inst), 64'd0);
        check("rst_issue_last", 64'(issue_last), 64'd0);
        check("rst_fetch_ready", 64'(fetch_ready), 64'd1);
        tick(1);
        rstn = 1'b1;
        tick(1);

        // Single SIB bundle, execute always ready.
        issue_ready = 1'b1;
        clear_bundle();
        put_slot(MQ_SCALE, MIOP_SLLI);
        put_slot(MQ_LOAD, MIOP_LD);
        fetch_pc = 32'h1000;
        send(20);
        tick(3);

        // Same bundle under back-pressure.
        issue_ready = 1'b0;
        send(20);
        tick(3);
        issue_ready = 1'b1;
        tick(3);

        // Back-to-back bundles.
        fill_bundle(N'(8'b0000_1010), 32'h10);
        send(20);
        fill_bundle(N'(8'b0001_0000), 32'h14);
        send(20);
        tick(3);

        // All-NOP bundle.
        clear_bundle();
        send(20);
        tick(2);

        // Flush after the first issue with a concurrent bundle offered.
        fill_bundle(N'(8'b0101_0001), 32'h20);
        send(20);
        tick(1);
        flush = 1'b1;
        fill_bundle(N'(8'b0000_0011), 32'h24);
        fetch_valid = 1'b1;
        tick(1);
        flush = 1'b0;
        fetch_valid = 1'b0;
        check("flush_issue_valid", 64'(issue_valid), 64'd0);
        check("flush_busy", 64'(busy), 64'd0);
        tick(3);

        // Asynchronous reset while slots are pending.
        issue_ready = 1'b0;
        fill_bundle(N'(8'b1100_0100), 32'h30);
        send(20);
        tick(1);
        #1;
        rstn = 1'b0;
        #1;
        check("async_rst_issue_valid", 64'(issue_valid), 64'd0);
        check("async_rst_busy", 64'(busy), 64'd0);
        tick(2);
        rstn = 1'b1;
        issue_ready = 1'b1;
        tick(5);

        // Random traffic.
        repeat (3000) begin
            issue_ready = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 29) == 0);
            fetch_valid = ($urandom_range(0, 9) < 6);
            if (fetch_valid) begin
                m = N'($urandom());
                if ($urandom_range(0, 7) == 0) m = '0;
                fill_bundle(m, $urandom());
            end
            tick(1);
        end
        flush       = 1'b0;
        fetch_valid = 1'b0;
        issue_ready = 1'b1;
        tick(20);
        check("drained", 64'(exp_q.size()), 64'd0);
        check("issued_some", 64'(n_issued > 100), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
